aer_uart_sched: RTL and testbench
=================================

AER_UART_SCHED -- requirements
Module: aer_uart_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, AER event buffer depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, max idle clocks between header byte and address byte.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tdata  input  8  received UART byte.
REQ-006 SHALL have port s_axis_tvalid  input  1  byte valid.
REQ-007 SHALL have port s_axis_tready  output  1  byte accepted when tvalid&tready at clk edge.
REQ-008 SHALL have port aer_addr  output  10  event address to neuromorphic core.
REQ-009 SHALL have port aer_req  output  1  four-phase request.
REQ-010 SHALL have port aer_ack  input  1  four-phase acknowledge (may be asynchronous to clk).
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered event count.
REQ-012 SHALL have port cmd_err  output  1  sticky flag: malformed header or timeout seen.
REQ-013 SHALL have port evt_count  output  16  events delivered, saturating at 0xFFFF.

Function
REQ-014 Parser FSM SHALL have states P_HDR and P_ADDR.
REQ-015 In P_HDR, accepted byte with [7:4]==4'b0010 and [3:2]==2'b00 SHALL latch [1:0] as addr[9:8] and go to P_ADDR.
REQ-016 In P_HDR, any other accepted byte SHALL be discarded and set cmd_err; state stays P_HDR.
REQ-017 In P_ADDR, accepted byte SHALL form {addr[9:8], byte} and be pushed into FIFO on the same edge; state returns to P_HDR.
REQ-018 s_axis_tready SHALL be 1 except in P_ADDR while FIFO full (backpressure, no event dropped by this block).
REQ-019 In P_ADDR, timeout counter SHALL count clocks without an accepted byte; on reaching TIMEOUT_CYC: discard header, set cmd_err, return to P_HDR; counter cleared on every state entry.
REQ-020 Address 0x1FF (time-reference event) SHALL be forwarded like any other address, no special handling.
REQ-021 aer_ack SHALL pass through a 2-flop synchronizer before use (ack_s).
REQ-022 Handshake FSM SHALL have states H_IDLE, H_REQ, H_REL.
REQ-023 H_IDLE with FIFO non-empty and ack_s==0: pop head, register aer_addr, set aer_req=1, go H_REQ; aer_req rises on the first edge after the entry is written.
REQ-024 H_REQ: hold aer_req and aer_addr stable until ack_s==1, then aer_req=0, increment evt_count, go H_REL.
REQ-025 H_REL: wait ack_s==0, then go H_IDLE; no new request before ack_s low.
REQ-026 Simultaneous FIFO push and pop SHALL leave fifo_level unchanged; push to full and pop from empty SHALL never occur.
REQ-027 aer_addr SHALL change only when aer_req rises.
REQ-028 evt_count SHALL hold at 0xFFFF once reached.

Reset
REQ-029 rst SHALL immediately force: aer_req=0, aer_addr=0, FIFO empty, fifo_level=0, cmd_err=0, evt_count=0, parser P_HDR, handshake H_IDLE, synchronizer flops 0, timeout counter 0.
REQ-030 s_axis_tready SHALL be 1 during and after reset; reset mid-handshake abandons the event (no retry).

Structure
REQ-031 Shared package aer_pkg SHALL hold AER_ADDR_W=10, CMD_OPCODE=4'b0010, typedef aer_addr_t, and parser/handshake state enums.
REQ-032 FIFO SHALL be sub-module aer_fifo (synchronous, registered head, full/empty/level outputs); parser, timeout, synchronizer and handshake FSM stay in aer_uart_sched.

Verification
REQ-033 Bytes 0x20,0x05, ack responder 3-cycle delay -> one aer_req with aer_addr=0x005, evt_count=1, cmd_err=0.
REQ-034 Bytes 0x21,0xFF -> aer_addr=0x1FF delivered; req held until ack_s high, no second req before ack_s low.
REQ-035 Byte 0x30 then 0x20,0x11 -> 0x30 discarded, cmd_err=1, exactly one event 0x011.
REQ-036 TIMEOUT_CYC=100: byte 0x20, 101 idle clocks, then 0x07 -> cmd_err=1, no event, parser in P_HDR.
REQ-037 aer_ack held 0-to-1 stuck high, send 17 commands -> first delivered, next 16 fill FIFO (fifo_level=16), s_axis_tready=0 in P_ADDR of 18th; release ack -> all drain in order.
REQ-038 rst asserted while aer_req=1 with fifo_level=5 -> aer_req=0 asynchronously, fifo_level=0, evt_count=0.

Source files
------------

// File: rtl/aer_pkg.sv
// aer_pkg: shared AER address type, command opcode and FSM state encodings
package aer_pkg;
  localparam int AER_ADDR_W = 10;
  localparam logic [3:0] CMD_OPCODE = 4'b0010;
  typedef logic [AER_ADDR_W-1:0] aer_addr_t;
  typedef enum logic {P_HDR, P_ADDR} p_state_t;
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} h_state_t;
endpackage

// File: rtl/aer_fifo.sv
// aer_fifo: power-of-two event FIFO with head read from the storage registers
module aer_fifo
  import aer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  aer_addr_t     din,
  input  logic          pop,
  output aer_addr_t     dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  aer_addr_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      if (push != pop) level <= push ? level + LW'(1) : level - LW'(1);
    end
  assign dout = mem[rd];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
endmodule

// File: rtl/aer_uart_sched.sv
// aer_uart_sched: parses 2-byte UART commands into AER events and delivers them
// over a four-phase req/ack handshake through a small FIFO.
module aer_uart_sched
  import aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT_CYC = 65535,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output aer_addr_t     aer_addr,
  output logic          aer_req,
  input  logic          aer_ack,
  output logic [LW-1:0] fifo_level,
  output logic          cmd_err,
  output logic [15:0]   evt_count
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  p_state_t p_st;
  h_state_t h_st;
  logic [1:0] hi;
  logic [TW-1:0] tcnt;
  logic ack_m, ack_s, full, empty, acc, push, pop;
  aer_addr_t head;
  assign s_axis_tready = !(p_st == P_ADDR && full);
  assign acc = s_axis_tvalid && s_axis_tready;
  assign push = acc && p_st == P_ADDR;
  assign pop = h_st == H_IDLE && !empty && !ack_s;
  aer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({hi, s_axis_tdata}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // tcnt counts idle clocks in P_ADDR, including clocks stalled by a full FIFO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_st <= P_HDR;
      hi <= '0;
      tcnt <= '0;
      cmd_err <= 1'b0;
    end else if (p_st == P_HDR) begin
      if (acc && s_axis_tdata[7:4] == CMD_OPCODE && s_axis_tdata[3:2] == 2'b00) begin
        hi <= s_axis_tdata[1:0];
        tcnt <= '0;
        p_st <= P_ADDR;
      end else if (acc) cmd_err <= 1'b1;
    end else if (acc) begin
      tcnt <= '0;
      p_st <= P_HDR;
    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
      tcnt <= '0;
      cmd_err <= 1'b1;
      p_st <= P_HDR;
    end else tcnt <= tcnt + TW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
      h_st <= H_IDLE;
      aer_req <= 1'b0;
      aer_addr <= '0;
      evt_count <= '0;
    end else begin
      ack_m <= aer_ack;
      ack_s <= ack_m;
      case (h_st)
        H_IDLE: if (pop) begin
          aer_addr <= head;
          aer_req <= 1'b1;
          h_st <= H_REQ;
        end
        H_REQ: if (ack_s) begin
          aer_req <= 1'b0;
          evt_count <= evt_count == 16'hFFFF ? evt_count : evt_count + 16'd1;
          h_st <= H_REL;
        end
        default: if (!ack_s) h_st <= H_IDLE;
      endcase
    end
endmodule

// File: tb/tb_aer_uart_sched.sv
// tb_aer_uart_sched: randomized UART command stream checked every cycle against
// an event-queue model of parsing, buffering and the four-phase handshake.
module tb_aer_uart_sched;
  localparam int DEPTH = 16;
  localparam int TMO = 100;
  logic clk = 0, rst = 1;
  logic [7:0] tdata = 0;
  logic tvalid = 0, tready;
  logic [9:0] aer_addr;
  logic aer_req, aer_ack = 0, cmd_err;
  logic [4:0] fifo_level;
  logic [15:0] evt_count;
  int n_cmp = 0, n_bad = 0;
  int ack_dly = 3, acnt = 0, n_cmd;
  bit stuck = 0, rnd = 0;
  always #5 clk = ~clk;
  aer_uart_sched #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .aer_addr(aer_addr),
    .aer_req(aer_req),
    .aer_ack(aer_ack),
    .fifo_level(fifo_level),
    .cmd_err(cmd_err),
    .evt_count(evt_count)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: queue of buffered events with the clock at which each was pushed
  logic [9:0] q[$];
  int st[$];
  bit m_in, m_err, a1, a2, a3, p_acc, p_ack;
  logic [1:0] m_hi;
  logic [7:0] p_data;
  logic [9:0] m_addr;
  int m_idle, m_h, m_evt, cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      st.delete();
      m_in = 0; m_err = 0; m_idle = 0; m_h = 0; m_evt = 0; m_addr = 0;
      a1 = 0; a2 = 0; a3 = 0;
    end else begin
      cyc++;
      a3 = a2; a2 = a1; a1 = p_ack;
      if (!m_in) begin
        if (p_acc && p_data[7:2] == 6'b001000) begin
          m_in = 1; m_hi = p_data[1:0]; m_idle = 0;
        end else if (p_acc) m_err = 1;
      end else if (p_acc) begin
        q.push_back({m_hi, p_data});
        st.push_back(cyc);
        m_in = 0;
      end else begin
        m_idle++;
        if (m_idle >= TMO) begin m_in = 0; m_err = 1; end
      end
      if (m_h == 0) begin
        if (q.size() > 0 && st[0] < cyc && !a3) begin
          m_addr = q.pop_front();
          void'(st.pop_front());
          m_h = 1;
        end
      end else if (m_h == 1) begin
        if (a3) begin m_h = 2; m_evt++; end
      end else if (!a3) m_h = 0;
      chk("aer_req", int'(aer_req), int'(m_h == 1));
      chk("aer_addr", int'(aer_addr), int'(m_addr));
      chk("fifo_level", int'(fifo_level), q.size());
      chk("tready", int'(tready), int'(!(m_in && q.size() == DEPTH)));
      chk("cmd_err", int'(cmd_err), int'(m_err));
      chk("evt_count", int'(evt_count), m_evt > 65535 ? 65535 : m_evt);
    end
    p_acc = tvalid && tready;
    p_data = tdata;
    p_ack = aer_ack;
  end
  // ack responder: raises ack ack_dly clocks after req, drops it after req falls
  initial forever begin
    @(posedge clk); #1;
    if (rst) begin aer_ack = 0; acnt = 0; end
    else if (aer_req && !aer_ack) begin
      if (acnt >= ack_dly) begin
        aer_ack = 1; acnt = 0;
        if (rnd) ack_dly = $urandom_range(0, 4);
      end else acnt++;
    end else if (!aer_req && aer_ack && !stuck) aer_ack = 0;
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 0; tdata = b; tvalid = 1;
    for (int i = 0; i < 400 && !ok; i++) begin ok = tready; tick(1); end
    tvalid = 0;
    chk("byte accepted", int'(ok), 1);
  endtask
  task automatic cmd(input logic [1:0] h, input logic [7:0] lo);
    send({6'b001000, h});
    send(lo);
  endtask
  task automatic wait_req(input string nm);
    for (int i = 0; i < 500 && !aer_req; i++) tick(1);
    chk(nm, int'(aer_req), 1);
  endtask
  task automatic wait_evt(input int n, input string nm);
    for (int i = 0; i < 3000 && int'(evt_count) != n; i++) tick(1);
    chk(nm, int'(evt_count), n);
  endtask
  task automatic do_reset;
    rst = 1; stuck = 0;
    tick(2);
    chk("tready in reset", int'(tready), 1);
    @(negedge clk); #1 rst = 0;
    tick(1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset;
    chk("reset aer_req", int'(aer_req), 0);
    chk("reset aer_addr", int'(aer_addr), 0);
    chk("reset fifo_level", int'(fifo_level), 0);
    chk("reset cmd_err", int'(cmd_err), 0);
    chk("reset evt_count", int'(evt_count), 0);
    chk("reset tready", int'(tready), 1);
    cmd(2'd0, 8'h05);
    wait_req("basic req");
    chk("basic addr", int'(aer_addr), 'h005);
    wait_evt(1, "basic evt_count");
    chk("basic cmd_err", int'(cmd_err), 0);
    cmd(2'd1, 8'hFF);
    wait_req("tref req");
    chk("tref addr", int'(aer_addr), 'h1FF);
    wait_evt(2, "tref evt_count");
    send(8'h30);
    tick(1);
    chk("bad hdr cmd_err", int'(cmd_err), 1);
    cmd(2'd0, 8'h11);
    wait_req("after bad hdr req");
    chk("after bad hdr addr", int'(aer_addr), 'h011);
    wait_evt(3, "after bad hdr evt_count");
    tick(20);
    chk("single event", int'(evt_count), 3);
    send(8'h22);
    tick(TMO - 1);
    send(8'h44);
    wait_req("late addr req");
    chk("late addr accepted", int'(aer_addr), 'h244);
    wait_evt(4, "late addr evt_count");
    do_reset;
    send(8'h20);
    tick(TMO + 1);
    send(8'h07);
    tick(10);
    chk("timeout cmd_err", int'(cmd_err), 1);
    chk("timeout no event", int'(evt_count), 0);
    chk("timeout fifo_level", int'(fifo_level), 0);
    cmd(2'd0, 8'h33);
    wait_req("post timeout req");
    chk("post timeout addr", int'(aer_addr), 'h033);
    wait_evt(1, "post timeout evt_count");
    do_reset;
    stuck = 1; ack_dly = 1;
    for (int i = 0; i < 17; i++) cmd(2'(i % 4), 8'(i * 13 + 1));
    for (int i = 0; i < 500 && int'(fifo_level) != DEPTH; i++) tick(1);
    chk("stuck fifo_level", int'(fifo_level), DEPTH);
    chk("stuck evt_count", int'(evt_count), 1);
    send(8'h23);
    chk("backpressure tready", int'(tready), 0);
    stuck = 0;
    send(8'h99);
    wait_evt(18, "drain evt_count");
    do_reset;
    rnd = 1; n_cmd = 0;
    for (int k = 0; k < 150; k++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        b = 8'($urandom);
        if (b[7:2] == 6'b001000) b = b ^ 8'h80;
        send(b);
      end else if (r == 1) begin
        send({6'b001000, 2'($urandom_range(0, 3))});
        tick(TMO + 5);
      end else begin
        tick($urandom_range(0, 3));
        cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        n_cmd++;
      end
    end
    for (int i = 0; i < 3000 && (q.size() != 0 || m_h == 1); i++) tick(1);
    tick(10);
    chk("random evt_count", int'(evt_count), n_cmd);
    do_reset;
    rnd = 0; ack_dly = 3;
    cmd(2'd3, 8'hA5);
    wait_evt(1, "pre-reset evt_count");
    ack_dly = 100000;
    for (int i = 0; i < 6; i++) cmd(2'd2, 8'(i + 8'h40));
    for (int i = 0; i < 500 && !(aer_req && int'(fifo_level) == 5); i++) tick(1);
    chk("pre-reset aer_req", int'(aer_req), 1);
    chk("pre-reset fifo_level", int'(fifo_level), 5);
    chk("pre-reset aer_addr", int'(aer_addr), 'h240);
    #2 rst = 1;
    #1;
    chk("async rst aer_req", int'(aer_req), 0);
    chk("async rst fifo_level", int'(fifo_level), 0);
    chk("async rst evt_count", int'(evt_count), 0);
    chk("async rst aer_addr", int'(aer_addr), 0);
    chk("async rst tready", int'(tready), 1);
    @(negedge clk); #1 rst = 0;
    ack_dly = 3;
    tick(20);
    chk("abandoned event", int'(evt_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
